// File: rtl/exec_pkg.sv
// Shared types and helpers for the RV32 execute stage: ALU opcodes, divider
// state encoding and opcode classification.
package exec_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
    ALU_SLT, ALU_SLTU, ALU_PASSB, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_t;

  typedef logic [1:0] div_state_t;
  localparam div_state_t DIV_IDLE = 2'd0;
  localparam div_state_t DIV_BUSY = 2'd1;
  localparam div_state_t DIV_DONE = 2'd2;

  localparam int          DIV_ITERS  = 32;
  localparam logic [31:0] DIV_ZERO_Q = '1;

  function automatic logic is_div_op(input alu_op_t op);
    return op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
  endfunction

  function automatic logic is_signed_div(input alu_op_t op);
    return op inside {ALU_DIV, ALU_REM};
  endfunction

  function automatic logic is_rem_op(input alu_op_t op);
    return op inside {ALU_REM, ALU_REMU};
  endfunction

endpackage

// File: rtl/execute_stage_divider.sv
// Iterative radix-2 restoring divider with magnitude conversion, sign fix-up
// and the RISC-V divide-by-zero / signed-overflow results.
//
// state | meaning
// IDLE  | waiting for start; special cases jump straight to DONE
// BUSY  | one shift-subtract per cycle, DIV_ITERS cycles
// DONE  | result valid for one cycle, then back to IDLE
module iterative_divider
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            flush_i,
  input  logic            signed_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic            stall_o,
  output logic            busy_o,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  localparam int CNT_W = $clog2(DIV_ITERS);

  div_state_t        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [XLEN-1:0]   quo_q, quo_d, rem_q, rem_d, dvs_q, dvs_d;
  logic              neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
  logic              special_q, special_d;

  logic              dvd_neg, dvs_neg, div_zero, overflow;
  logic [XLEN-1:0]   dvd_mag, dvs_mag;
  logic [XLEN:0]     rem_sh, diff;

  assign dvd_neg  = signed_i & dividend_i[XLEN-1];
  assign dvs_neg  = signed_i & divisor_i[XLEN-1];
  assign dvd_mag  = dvd_neg ? -dividend_i : dividend_i;
  assign dvs_mag  = dvs_neg ? -divisor_i : divisor_i;
  assign div_zero = (divisor_i == '0);
  assign overflow = signed_i && (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                    && (divisor_i == '1);

  // quo_q doubles as the dividend shift register: its MSB feeds the remainder
  assign rem_sh = {rem_q, quo_q[XLEN-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    special_d = special_q;
    case (state_q)
      DIV_IDLE: begin
        if (start_i) begin
          neg_quo_d = dvd_neg ^ dvs_neg;
          neg_rem_d = dvd_neg;
          if (div_zero) begin
            quo_d     = XLEN'(DIV_ZERO_Q);
            rem_d     = dividend_i;
            special_d = 1'b1;
            state_d   = DIV_DONE;
          end else if (overflow) begin
            quo_d     = dividend_i;
            rem_d     = '0;
            special_d = 1'b1;
            state_d   = DIV_DONE;
          end else begin
            quo_d     = dvd_mag;
            rem_d     = '0;
            dvs_d     = dvs_mag;
            count_d   = '0;
            special_d = 1'b0;
            state_d   = DIV_BUSY;
          end
        end
      end
      DIV_BUSY: begin
        if (flush_i) begin
          state_d = DIV_IDLE;
        end else begin
          if (!diff[XLEN]) begin
            rem_d = diff[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = rem_sh[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (count_q == CNT_W'(DIV_ITERS - 1)) state_d = DIV_DONE;
          else                                  count_d = count_q + 1'b1;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= DIV_IDLE;
      count_q   <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      special_q <= special_d;
    end
  end

  assign stall_o     = ((state_q == DIV_IDLE) && start_i) ||
                       ((state_q == DIV_BUSY) && !flush_i);
  assign busy_o      = (state_q != DIV_IDLE);
  assign quotient_o  = (special_q || !neg_quo_q) ? quo_q : -quo_q;
  assign remainder_o = (special_q || !neg_rem_q) ? rem_q : -rem_q;

endmodule

// File: rtl/execute_stage.sv
// RV32 EX stage: operand mux, single-cycle ALU/multiplier, iterative divider
// hookup and the EX/MEM pipeline register.
module execute_stage
  import exec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_ex,
  input  logic             flush_ex,
  input  logic [4:0]       alu_op_ex,
  input  logic             alu_src_ex,
  input  logic [XLEN-1:0]  reg1_data_ex,
  input  logic [XLEN-1:0]  reg2_data_ex,
  input  logic [XLEN-1:0]  imm_ex,
  input  logic [XLEN-1:0]  pc_ex,
  input  logic [REG_W-1:0] wrt_reg_ex,
  input  logic             reg_wrt_en_ex,
  input  logic             mem_rd_en_ex,
  input  logic             mem_wrt_en_ex,
  input  logic             mem_unsigned_ex,
  input  logic             random_ex,
  input  logic             rdi_ex,
  input  logic [1:0]       width_ex,
  input  logic [1:0]       wb_sel_ex,
  output logic             stall_ex,
  output logic             div_busy,
  output logic             reg_wrt_en_mem,
  output logic             mem_rd_en_mem,
  output logic             mem_wrt_en_mem,
  output logic             mem_unsigned_mem,
  output logic             random_mem,
  output logic             rdi_mem,
  output logic [1:0]       width_mem,
  output logic [1:0]       wb_sel_mem,
  output logic [REG_W-1:0] wrt_reg_mem,
  output logic [XLEN-1:0]  pc_mem,
  output logic [XLEN-1:0]  reg2_data_mem,
  output logic [XLEN-1:0]  alu_mem
);

  alu_op_t             op;
  logic [XLEN-1:0]     op_a, op_b, result, quotient, remainder;
  logic [2*XLEN-1:0]   mul_a, mul_b, prod;
  logic                mul_a_sgn, mul_b_sgn, div_start, div_stall, load_mem;
  logic [9:0]          ctl_ex, ctl_q, ctl_d;
  logic [REG_W-1:0]    wrt_reg_q, wrt_reg_d;
  logic [XLEN-1:0]     pc_q, pc_d, reg2_q, reg2_d, alu_q, alu_d;

  assign op   = alu_op_t'(alu_op_ex);
  assign op_a = reg1_data_ex;
  assign op_b = alu_src_ex ? imm_ex : reg2_data_ex;

  // one 2*XLEN multiplier; per-op sign extension selects MUL/MULH/MULHSU/MULHU
  assign mul_a_sgn = (op == ALU_MULH) || (op == ALU_MULHSU);
  assign mul_b_sgn = (op == ALU_MULH);
  assign mul_a     = {{XLEN{mul_a_sgn & op_a[XLEN-1]}}, op_a};
  assign mul_b     = {{XLEN{mul_b_sgn & op_b[XLEN-1]}}, op_b};
  assign prod      = mul_a * mul_b;

  always_comb begin
    result = '0;
    case (op)
      ALU_ADD:    result = op_a + op_b;
      ALU_SUB:    result = op_a - op_b;
      ALU_AND:    result = op_a & op_b;
      ALU_OR:     result = op_a | op_b;
      ALU_XOR:    result = op_a ^ op_b;
      ALU_SLL:    result = op_a << op_b[4:0];
      ALU_SRL:    result = op_a >> op_b[4:0];
      ALU_SRA:    result = $signed(op_a) >>> op_b[4:0];
      ALU_SLT:    result = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      ALU_SLTU:   result = {{(XLEN-1){1'b0}}, op_a < op_b};
      ALU_PASSB:  result = op_b;
      ALU_MUL:    result = prod[XLEN-1:0];
      ALU_MULH, ALU_MULHSU, ALU_MULHU: result = prod[2*XLEN-1:XLEN];
      ALU_DIV, ALU_DIVU: result = quotient;
      ALU_REM, ALU_REMU: result = remainder;
      default:    result = '0;
    endcase
  end

  assign div_start = valid_ex && !flush_ex && is_div_op(op);

  iterative_divider #(.XLEN(XLEN)) u_div (
    .clk         (clk),
    .rst         (rst),
    .start_i     (div_start),
    .flush_i     (flush_ex),
    .signed_i    (is_signed_div(op)),
    .dividend_i  (op_a),
    .divisor_i   (op_b),
    .stall_o     (div_stall),
    .busy_o      (div_busy),
    .quotient_o  (quotient),
    .remainder_o (remainder)
  );

  // reset forces stall low even while a divide op sits in EX
  assign stall_ex = div_stall && !rst;
  assign load_mem = valid_ex && !flush_ex && !stall_ex;

  assign ctl_ex = {reg_wrt_en_ex, mem_rd_en_ex, mem_wrt_en_ex, mem_unsigned_ex,
                   random_ex, rdi_ex, width_ex, wb_sel_ex};

  assign ctl_d     = load_mem ? ctl_ex       : '0;
  assign wrt_reg_d = load_mem ? wrt_reg_ex   : '0;
  assign pc_d      = load_mem ? pc_ex        : '0;
  assign reg2_d    = load_mem ? reg2_data_ex : '0;
  assign alu_d     = load_mem ? result       : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctl_q     <= '0;
      wrt_reg_q <= '0;
      pc_q      <= '0;
      reg2_q    <= '0;
      alu_q     <= '0;
    end else begin
      ctl_q     <= ctl_d;
      wrt_reg_q <= wrt_reg_d;
      pc_q      <= pc_d;
      reg2_q    <= reg2_d;
      alu_q     <= alu_d;
    end
  end

  assign {reg_wrt_en_mem, mem_rd_en_mem, mem_wrt_en_mem, mem_unsigned_mem,
          random_mem, rdi_mem, width_mem, wb_sel_mem} = ctl_q;
  assign wrt_reg_mem   = wrt_reg_q;
  assign pc_mem        = pc_q;
  assign reg2_data_mem = reg2_q;
  assign alu_mem       = alu_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: expected EX/MEM bundles are queued when an
// instruction is driven and popped when the stage releases it into MEM.
module tb_execute_stage;
  import exec_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_ex = 1'b0, flush_ex = 1'b0, alu_src_ex = 1'b0;
  logic [4:0]  alu_op_ex = '0;
  logic [31:0] reg1_data_ex = '0, reg2_data_ex = '0, imm_ex = '0, pc_ex = '0;
  logic [4:0]  wrt_reg_ex = '0;
  logic        reg_wrt_en_ex = 1'b0, mem_rd_en_ex = 1'b0, mem_wrt_en_ex = 1'b0;
  logic        mem_unsigned_ex = 1'b0, random_ex = 1'b0, rdi_ex = 1'b0;
  logic [1:0]  width_ex = '0, wb_sel_ex = '0;

  logic        stall_ex, div_busy;
  logic        reg_wrt_en_mem, mem_rd_en_mem, mem_wrt_en_mem, mem_unsigned_mem;
  logic        random_mem, rdi_mem;
  logic [1:0]  width_mem, wb_sel_mem;
  logic [4:0]  wrt_reg_mem;
  logic [31:0] pc_mem, reg2_data_mem, alu_mem;

  execute_stage dut (
    .clk (clk), .rst (rst), .valid_ex (valid_ex), .flush_ex (flush_ex),
    .alu_op_ex (alu_op_ex), .alu_src_ex (alu_src_ex),
    .reg1_data_ex (reg1_data_ex), .reg2_data_ex (reg2_data_ex),
    .imm_ex (imm_ex), .pc_ex (pc_ex), .wrt_reg_ex (wrt_reg_ex),
    .reg_wrt_en_ex (reg_wrt_en_ex), .mem_rd_en_ex (mem_rd_en_ex),
    .mem_wrt_en_ex (mem_wrt_en_ex), .mem_unsigned_ex (mem_unsigned_ex),
    .random_ex (random_ex), .rdi_ex (rdi_ex),
    .width_ex (width_ex), .wb_sel_ex (wb_sel_ex),
    .stall_ex (stall_ex), .div_busy (div_busy),
    .reg_wrt_en_mem (reg_wrt_en_mem), .mem_rd_en_mem (mem_rd_en_mem),
    .mem_wrt_en_mem (mem_wrt_en_mem), .mem_unsigned_mem (mem_unsigned_mem),
    .random_mem (random_mem), .rdi_mem (rdi_mem),
    .width_mem (width_mem), .wb_sel_mem (wb_sel_mem),
    .wrt_reg_mem (wrt_reg_mem), .pc_mem (pc_mem),
    .reg2_data_mem (reg2_data_mem), .alu_mem (alu_mem)
  );

  always #5 clk = ~clk;

  wire [110:0] mem_bus = {reg_wrt_en_mem, mem_rd_en_mem, mem_wrt_en_mem,
                          mem_unsigned_mem, random_mem, rdi_mem, width_mem,
                          wb_sel_mem, wrt_reg_mem, pc_mem, reg2_data_mem, alu_mem};

  int           tests = 0;
  int           fails = 0;
  int           k = 0;
  logic [9:0]   last_ctl;
  logic [110:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input alu_op_t op, input logic src,
                       input logic [31:0] a, input logic [31:0] r2,
                       input logic [31:0] imm);
    @(negedge clk);
    last_ctl     = 10'($urandom);
    valid_ex     = 1'b1;
    alu_op_ex    = op;
    alu_src_ex   = src;
    reg1_data_ex = a;
    reg2_data_ex = r2;
    imm_ex       = imm;
    pc_ex        = 32'h0000_1000 + 32'(k * 4);
    wrt_reg_ex   = 5'(k + 1);
    {reg_wrt_en_ex, mem_rd_en_ex, mem_wrt_en_ex, mem_unsigned_ex,
     random_ex, rdi_ex, width_ex, wb_sel_ex} = last_ctl;
    k++;
  endtask

  task automatic run(input string tag, input alu_op_t op, input logic src,
                     input logic [31:0] a, input logic [31:0] r2,
                     input logic [31:0] imm, input logic [31:0] exp_alu,
                     input int exp_stall);
    int   n;
    logic bubbles_ok;
    n = 0;
    bubbles_ok = 1'b1;
    drive(op, src, a, r2, imm);
    exp_q.push_back({last_ctl, wrt_reg_ex, pc_ex, r2, exp_alu});
    #1;
    while (stall_ex === 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
      if (mem_bus !== '0) bubbles_ok = 1'b0;
    end
    check({tag, " stall cycles"}, 128'(n), 128'(exp_stall));
    if (n > 0) check({tag, " bubbles"}, 128'(bubbles_ok), 128'(1));
    @(posedge clk);
    #1;
    check({tag, " alu_mem"}, 128'(alu_mem), 128'(exp_alu));
    check({tag, " bundle"}, 128'(mem_bus), 128'(exp_q.pop_front()));
    valid_ex = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset bundle", 128'(mem_bus), 128'(0));
    check("reset div_busy", 128'(div_busy), 128'(0));
    check("reset stall", 128'(stall_ex), 128'(0));
    @(negedge clk);
    rst = 1'b0;

    run("add imm",   ALU_ADD,    1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'hFFFF_FFF0, 32'h0000_0000, 0);
    run("sub",       ALU_SUB,    1'b0, 32'd5,         32'd7,         32'h0,         32'hFFFF_FFFE, 0);
    run("sra",       ALU_SRA,    1'b1, 32'h8000_0000, 32'h1234_5678, 32'd4,         32'hF800_0000, 0);
    run("slt",       ALU_SLT,    1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'd1,         0);
    run("sltu",      ALU_SLTU,   1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0,         32'd0,         0);
    run("mul",       ALU_MUL,    1'b0, 32'hFFFF_FFFF, 32'd3,         32'h0,         32'hFFFF_FFFD, 0);
    run("mulh",      ALU_MULH,   1'b0, 32'hFFFF_FFFF, 32'd3,         32'h0,         32'hFFFF_FFFF, 0);
    run("mulhsu",    ALU_MULHSU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0,         32'hFFFF_FFFF, 0);
    run("passb",     ALU_PASSB,  1'b1, 32'h0000_0001, 32'h0000_0002, 32'h1234_5000, 32'h1234_5000, 0);

    run("div -7/2",  ALU_DIV,    1'b0, 32'hFFFF_FFF9, 32'd2,         32'h0,         32'hFFFF_FFFD, 33);
    run("rem -7%2",  ALU_REM,    1'b0, 32'hFFFF_FFF9, 32'd2,         32'h0,         32'hFFFF_FFFF, 33);
    run("divu /0",   ALU_DIVU,   1'b0, 32'd100,       32'd0,         32'h0,         32'hFFFF_FFFF, 1);
    run("remu %0",   ALU_REMU,   1'b0, 32'd100,       32'd0,         32'h0,         32'd100,       1);
    run("div ovf",   ALU_DIV,    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 1);
    run("rem ovf",   ALU_REM,    1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'd0,         1);
    run("divu 100/7",ALU_DIVU,   1'b0, 32'd100,       32'd7,         32'h0,         32'd14,        33);
    run("remu 100%7",ALU_REMU,   1'b0, 32'd100,       32'd7,         32'h0,         32'd2,         33);
    run("div -5/0",  ALU_DIV,    1'b0, 32'hFFFF_FFFB, 32'd0,         32'h0,         32'hFFFF_FFFF, 1);
    run("rem -5%0",  ALU_REM,    1'b0, 32'hFFFF_FFFB, 32'd0,         32'h0,         32'hFFFF_FFFB, 1);
    run("div imm",   ALU_DIV,    1'b1, 32'd1000,      32'd1,         32'hFFFF_FFF6, 32'hFFFF_FF9C, 33);

    // flush while BUSY at count 10
    drive(ALU_DIVU, 1'b0, 32'd1000, 32'd3, 32'h0);
    repeat (11) @(posedge clk);
    #1;
    check("flush pre busy", 128'(div_busy), 128'(1));
    check("flush pre stall", 128'(stall_ex), 128'(1));
    flush_ex = 1'b1;
    #1;
    check("flush stall drop", 128'(stall_ex), 128'(0));
    @(posedge clk);
    #1;
    check("flush bubble", 128'(mem_bus), 128'(0));
    check("flush idle", 128'(div_busy), 128'(0));
    valid_ex = 1'b0;
    flush_ex = 1'b0;
    run("add after flush", ALU_ADD, 1'b0, 32'd3, 32'd4, 32'h0, 32'd7, 0);

    // reset while BUSY at count 5
    drive(ALU_DIV, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'h0);
    repeat (6) @(posedge clk);
    #1;
    check("rst pre busy", 128'(div_busy), 128'(1));
    rst = 1'b1;
    #1;
    check("rst bundle", 128'(mem_bus), 128'(0));
    check("rst div_busy", 128'(div_busy), 128'(0));
    check("rst stall", 128'(stall_ex), 128'(0));
    @(negedge clk);
    valid_ex = 1'b0;
    rst = 1'b0;
    #1;
    check("post rst idle", 128'(div_busy), 128'(0));
    run("mulhu after rst", ALU_MULHU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFE, 0);

    check("scoreboard empty", 128'(exp_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
